seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//   Time-multiplexed N-digit hex 7-segment display driver for board debug output (PC, register, ALU result).
//   Captures a packed hex value and drives one shared segment bus plus one-hot digit enables, one digit per scan slot.
//   Double-buffered: a new value takes effect only at a frame boundary, so no frame mixes old and new digits.
// PARAMETERS
//   NUM_DIGITS     4      digits driven; value_in is 4*NUM_DIGITS bits, digit k = value_in[4k+3:4k]
//   PRESCALE       50000  clk cycles per digit slot; legal range >= 1 (1 = advance every cycle)
//   SEG_ACTIVE_LOW 0      1: seg_out, dp_out, digit_sel inverted at the output pins
// PORTS
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   value_in   in   4*NUM_DIGITS  hex value to display
//   dp_in      in   NUM_DIGITS    decimal point per digit, captured with value_in
//   load       in   1             capture value_in/dp_in into the pending buffer
//   enable     in   1             1: scan runs; 0: scan frozen, display dark
//   seg_out    out  7             segments {g,f,e,d,c,b,a}, bit0=a; active-high when SEG_ACTIVE_LOW=0
//   dp_out     out  1             decimal point of the current digit
//   digit_sel  out  NUM_DIGITS    one-hot digit enable; bit k = digit k
//   frame_done out  1             1-cycle pulse when scan wraps from digit NUM_DIGITS-1 to digit 0
// BEHAVIOUR
//   Reset (async, no clock): prescaler=0, index=0, disp/pending buffers=0, pend_flag=0, frame_done=0;
//     seg_out, dp_out, digit_sel at the "off" level (all 0, or all 1 when SEG_ACTIVE_LOW=1).
//   Prescaler counts 0..PRESCALE-1 while enable=1. At PRESCALE-1 it wraps to 0 and index advances; NUM_DIGITS-1 wraps to 0.
//   Index wrap to 0 = frame boundary: frame_done=1 for that cycle; if pend_flag, disp<=pending, pend_flag<=0.
//   load=1: pending<=value_in/dp_in, pend_flag<=1. Back-to-back loads: last one before the boundary wins.
//   load=1 on a boundary cycle: disp takes value_in/dp_in directly, pend_flag ends 0 (no one-frame lag).
//   Outputs registered: one cycle after index changes, digit_sel=1<<index, seg_out=hex code of disp digit[index], dp_out=disp dp[index].
//   Hex codes (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C C=39 d=5E E=79 F=71.
//   enable=0: prescaler and index hold. The next cycle drives digit_sel, seg_out and dp_out off; frame_done=0.
//     load is still accepted. After enable returns to 1, the held digit is output one cycle later and counting resumes from the held count.
//   Exactly one digit_sel bit is active whenever enable=1 after reset; never two bits in one cycle.
//   Widths: prescaler $clog2(PRESCALE+1) bits; index $clog2(NUM_DIGITS) bits (min 1); no overflow beyond wrap values.
// CONFIGURATION
//   SEG7_LEADING_ZERO_BLANK_EN defined: every digit k>0 whose nibble is 0 with all higher nibbles 0 shows blank segments.
//     Its dp and digit_sel stay active. Digit 0 is never blanked (value 0 shows "0").
//   Not defined: all digits show their hex code, including leading zeros.
// STRUCTURE
//   Package seg7_pkg: SEG7_W=7, 7-bit segment code constants SEG7_0..SEG7_F, SEG7_BLANK, function seg7_encode(nibble).
//   Sub-module seg7_hex_lut: combinational 4-bit -> 7-bit active-high encoder, one instance on the selected nibble.
//   Top holds prescaler, scan index, pending/disp buffers, blank logic, polarity inversion, output registers.
// TESTING  (NUM_DIGITS=4, PRESCALE=4, SEG_ACTIVE_LOW=0 unless stated)
//   1 Reset, enable=1, load 16'h1234 -> first frame after the boundary: digit_sel 0001/0010/0100/1000, 4 cycles each.
//       Matching seg_out 66/4F/5B/06. frame_done pulses every 16 cycles.
//   2 Mid-frame load 16'hABCD -> remaining slots still show 1234; after frame_done: 5E/39/7C/77.
//   3 load coincident with boundary, value 16'h00FF -> the frame that starts now shows 71/71/3F/3F (no lag).
//   4 enable=0 in slot 2, count 1 for 10 cycles -> outputs off next cycle, index unchanged.
//       enable=1 -> digit_sel=0100 one cycle later; slot ends 3 cycles after re-enable.
//   5 rst_n low mid-slot, no clk edge -> digit_sel/seg_out/dp_out/frame_done 0 immediately; after release, pending empty, disp=0.
//   6 Macro defined, value 16'h0050 -> digits 3,2 seg 00, digit1 6D, digit0 3F; value 0 -> only digit0 3F.
//   7 SEG_ACTIVE_LOW=1, value 16'h1234 -> seg_out 19/30/24/79, digit_sel 1110/1101/1011/0111; off/reset level all 1s.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - 7-segment code constants and hex encoder function
package seg7_pkg;

  localparam int SEG7_W = 7;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG7_W-1:0] SEG7_0     = 7'h3F;
  localparam logic [SEG7_W-1:0] SEG7_1     = 7'h06;
  localparam logic [SEG7_W-1:0] SEG7_2     = 7'h5B;
  localparam logic [SEG7_W-1:0] SEG7_3     = 7'h4F;
  localparam logic [SEG7_W-1:0] SEG7_4     = 7'h66;
  localparam logic [SEG7_W-1:0] SEG7_5     = 7'h6D;
  localparam logic [SEG7_W-1:0] SEG7_6     = 7'h7D;
  localparam logic [SEG7_W-1:0] SEG7_7     = 7'h07;
  localparam logic [SEG7_W-1:0] SEG7_8     = 7'h7F;
  localparam logic [SEG7_W-1:0] SEG7_9     = 7'h67;
  localparam logic [SEG7_W-1:0] SEG7_A     = 7'h77;
  localparam logic [SEG7_W-1:0] SEG7_B     = 7'h7C;
  localparam logic [SEG7_W-1:0] SEG7_C     = 7'h39;
  localparam logic [SEG7_W-1:0] SEG7_D     = 7'h5E;
  localparam logic [SEG7_W-1:0] SEG7_E     = 7'h79;
  localparam logic [SEG7_W-1:0] SEG7_F     = 7'h71;
  localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'h00;

  function automatic logic [SEG7_W-1:0] seg7_encode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG7_0;
      4'h1:    return SEG7_1;
      4'h2:    return SEG7_2;
      4'h3:    return SEG7_3;
      4'h4:    return SEG7_4;
      4'h5:    return SEG7_5;
      4'h6:    return SEG7_6;
      4'h7:    return SEG7_7;
      4'h8:    return SEG7_8;
      4'h9:    return SEG7_9;
      4'hA:    return SEG7_A;
      4'hB:    return SEG7_B;
      4'hC:    return SEG7_C;
      4'hD:    return SEG7_D;
      4'hE:    return SEG7_E;
      default: return SEG7_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational 4-bit to 7-segment active-high encoder
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0]        nibble,
  output logic [SEG7_W-1:0] seg
);

  always_comb begin
    seg = seg7_encode(nibble);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - double-buffered multiplexed hex 7-segment scan driver
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [SEG7_W-1:0]       seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int PRESC_W = $clog2(PRESCALE + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic               POL        = (SEG_ACTIVE_LOW != 0);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [SEG7_W-1:0]     seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, frame_end, lead_blank;
  logic [3:0]            nibble;
  logic [SEG7_W-1:0]     lut_seg;

  assign nibble = 4'(disp_val_q >> {idx_q, 2'b00});

  seg7_hex_lut u_lut (
    .nibble (nibble),
    .seg    (lut_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank when this nibble and everything above it is zero; digit 0 always shows
  assign lead_blank = (idx_q != '0) && ((disp_val_q >> {idx_q, 2'b00}) == '0);
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    slot_end  = enable && (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (slot_end) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (frame_end) begin
      // A load landing on the boundary bypasses the pending buffer
      if (load) begin
        disp_val_d = value_in;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end

    sel_d = '0;
    seg_d = SEG7_BLANK;
    dp_d  = 1'b0;
    if (enable) begin
      sel_d = NUM_DIGITS'(1) << idx_q;
      seg_d = lead_blank ? SEG7_BLANK : lut_seg;
      dp_d  = disp_dp_q[idx_q];
    end
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q ^ {SEG7_W{POL}};
  assign dp_out     = dp_q ^ POL;
  assign digit_sel  = sel_q ^ {NUM_DIGITS{POL}};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - self-checking bench for seven_seg_scan_driver (active-high and active-low builds)
module tb_seven_seg_scan_driver;

  localparam int N = 4;
  localparam int P = 4;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;
  logic [3:0]  sel_a, sel_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .SEG_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load), .enable(enable),
    .seg_out(seg_a), .dp_out(dp_a), .digit_sel(sel_a), .frame_done(fd_a));

  seven_seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load), .enable(enable),
    .seg_out(seg_b), .dp_out(dp_b), .digit_sel(sel_b), .frame_done(fd_b));

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k);
    logic [15:0] t;
    t = v >> (4 * k);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (k > 0 && t == 16'h0) return 7'h00;
`endif
    return hex_tab[t[3:0]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: position in the scan follows from the count of enabled cycles
  int          n_en;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic [3:0]  e_sel;
  logic        e_dp, e_fd;

  always @(posedge clk or negedge rst_n) begin
    int  k;
    bit  bnd;
    if (!rst_n) begin
      n_en <= 0; m_val <= '0; m_pval <= '0; m_dp <= '0; m_pdp <= '0; m_pend <= 1'b0;
      e_seg <= '0; e_sel <= '0; e_dp <= 1'b0; e_fd <= 1'b0;
    end else begin
      k   = (n_en / P) % N;
      bnd = enable && (((n_en + 1) % (P * N)) == 0);
      if (enable) begin
        e_sel <= 4'(1 << k);
        e_seg <= ref_seg(m_val, k);
        e_dp  <= m_dp[k];
        n_en  <= n_en + 1;
      end else begin
        e_sel <= '0; e_seg <= '0; e_dp <= 1'b0;
      end
      e_fd <= bnd;
      if (bnd) begin
        if (load) begin
          m_val <= value_in; m_dp <= dp_in;
        end else if (m_pend) begin
          m_val <= m_pval; m_dp <= m_pdp;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_pval <= value_in; m_pdp <= dp_in; m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_a", {sel_a, seg_a, dp_a, fd_a}, {e_sel, e_seg, e_dp, e_fd});
    chk("model_b", {sel_b, seg_b, dp_b, fd_b}, {~e_sel, ~e_seg, ~e_dp, e_fd});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fd_a) return;
    end
    total++;
    bad++;
    $display("FAIL fd_timeout: frame_done not seen in 100 cycles at %0t", $time);
  endtask

  task automatic check_frame(input logic [3:0] dp, input logic [27:0] segs);
    logic [6:0] s, sb;
    logic [3:0] sel, selb;
    for (int k = 0; k < N; k++) begin
      s    = segs[7*k +: 7];
      sb   = ~s;
      sel  = 4'(1 << k);
      selb = ~sel;
      for (int j = 0; j < P; j++) begin
        @(negedge clk);
        chk("tab_sel", sel_a, sel);
        chk("tab_seg", seg_a, s);
        chk("tab_dp", dp_a, dp[k]);
        chk("tab_sel_b", sel_b, selb);
        chk("tab_seg_b", seg_b, sb);
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [27:0] segs;
  } vec_t;

  vec_t tab [6];

  initial begin
    tab[0] = '{val: 16'h1234, dp: 4'h0, segs: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tab[1] = '{val: 16'hABCD, dp: 4'h1, segs: {7'h77, 7'h7C, 7'h39, 7'h5E}};
    tab[2] = '{val: 16'h8E07, dp: 4'hA, segs: {7'h7F, 7'h79, 7'h3F, 7'h07}};
    tab[3] = '{val: 16'h0050, dp: 4'h0, segs: {LZ, LZ, 7'h6D, 7'h3F}};
    tab[4] = '{val: 16'h0000, dp: 4'h4, segs: {LZ, LZ, LZ, 7'h3F}};
    tab[5] = '{val: 16'hF00F, dp: 4'hF, segs: {7'h71, 7'h3F, 7'h3F, 7'h71}};

    cyc(2);
    chk("rst_pins_a", {sel_a, seg_a, dp_a, fd_a}, 13'h0);
    chk("rst_pins_b", {sel_b, seg_b, dp_b}, 12'hFFF);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 6; i++) begin
      value_in = tab[i].val;
      dp_in    = tab[i].dp;
      load     = 1'b1;
      cyc(1);
      load = 1'b0;
      wait_fd();
      check_frame(tab[i].dp, tab[i].segs);
      chk("fd_period", fd_a, 1'b1);
    end

    // Load on the boundary cycle: the frame starting now must already show it
    cyc(15);
    value_in = 16'h00FF;
    dp_in    = 4'h0;
    load     = 1'b1;
    cyc(1);
    chk("bnd_fd", fd_a, 1'b1);
    load = 1'b0;
    check_frame(4'h0, {LZ, LZ, 7'h71, 7'h71});

    // Freeze in slot 2 with the prescaler at 1
    cyc(9);
    chk("frz_pre_sel", sel_a, 4'b0100);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("frz_off_a", {sel_a, seg_a, dp_a, fd_a}, 13'h0);
      chk("frz_off_b", {sel_b, seg_b, dp_b}, 12'hFFF);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("frz_resume_sel", sel_a, 4'b0100);
    end
    cyc(1);
    chk("frz_next_sel", sel_a, 4'b1000);

    // Asynchronous reset mid-slot discards a pending value
    cyc(2);
    value_in = 16'h9999;
    dp_in    = 4'hF;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pins_a", {sel_a, seg_a, dp_a, fd_a}, 13'h0);
    chk("arst_pins_b", {sel_b, seg_b, dp_b}, 12'hFFF);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_first", {sel_a, seg_a, dp_a}, {4'b0001, 7'h3F, 1'b0});
    wait_fd();
    check_frame(4'h0, {LZ, LZ, LZ, 7'h3F});

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
